// File: rtl/ddr3_readout_pkg.sv
// Shared definitions for the DDR3 readout sequencer: header field layout and FSM states.
package ddr3_readout_pkg;

  localparam int ADDR_LSB = 0;
  localparam int CNT_LSB  = 23;
  localparam int INFO_LSB = 47;
  localparam int HDR_W    = 152;
  localparam int INFO_W   = HDR_W - INFO_LSB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POP,
    ST_LATCH,
    ST_HDR,
    ST_ARM,
    ST_READ,
    ST_CHECK
  } seq_state_e;

endpackage

// File: rtl/ddr3_readout_sequencer.sv
// Pops one fill header, arms the DDR3 read engine, audits the returning bursts.
// Optional watchdog on the READ state: define READOUT_WATCHDOG_EN to add err_timeout.
module ddr3_readout_sequencer
  import ddr3_readout_pkg::*;
#(
  parameter int          ADDR_W         = 23,
  parameter int          CNT_W          = 24,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd16777215
) (
  input  logic              clk125,
  input  logic              reset_clk125,
  input  logic              readout_pause,
  input  logic              fill_header_fifo_empty,
  output logic              fill_header_fifo_rd_en,
  input  logic [HDR_W-1:0]  fill_header_fifo_out,
  output logic [ADDR_W-1:0] ddr3_rd_start_addr,
  output logic [CNT_W-1:0]  ddr3_rd_burst_cnt,
  output logic              enable_reading,
  input  logic              reading_done,
  input  logic              ddr3_rd_fifo_wr_en,
  input  logic              ddr3_rd_fifo_input_tlast,
  output logic [INFO_W-1:0] hdr_info,
  output logic              hdr_valid,
  input  logic              hdr_ack,
  output logic [23:0]       fills_read,
`ifdef READOUT_WATCHDOG_EN
  output logic              err_timeout,
`endif
  output logic              err_burst_mismatch,
  output logic              err_tlast,
  output logic              seq_idle
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [INFO_W-1:0] info_q, info_d;
  logic [CNT_W-1:0]  burst_ctr_q, burst_ctr_d;
  logic              last_tlast_q, last_tlast_d;
  logic              tlast_bad_q, tlast_bad_d;
  logic [1:0]        guard_q, guard_d;
  logic [23:0]       fills_q, fills_d;
  logic              err_burst_q, err_burst_d;
  logic              err_tlast_q, err_tlast_d;
`ifdef READOUT_WATCHDOG_EN
  logic [23:0]       wd_q, wd_d;
  logic              err_timeout_q, err_timeout_d;
`else
  logic              unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk125) begin
    if (reset_clk125) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      info_q        <= '0;
      burst_ctr_q   <= '0;
      last_tlast_q  <= 1'b0;
      tlast_bad_q   <= 1'b0;
      guard_q       <= '0;
      fills_q       <= '0;
      err_burst_q   <= 1'b0;
      err_tlast_q   <= 1'b0;
`ifdef READOUT_WATCHDOG_EN
      wd_q          <= '0;
      err_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      info_q        <= info_d;
      burst_ctr_q   <= burst_ctr_d;
      last_tlast_q  <= last_tlast_d;
      tlast_bad_q   <= tlast_bad_d;
      guard_q       <= guard_d;
      fills_q       <= fills_d;
      err_burst_q   <= err_burst_d;
      err_tlast_q   <= err_tlast_d;
`ifdef READOUT_WATCHDOG_EN
      wd_q          <= wd_d;
      err_timeout_q <= err_timeout_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    info_d        = info_q;
    burst_ctr_d   = burst_ctr_q;
    last_tlast_d  = last_tlast_q;
    tlast_bad_d   = tlast_bad_q;
    guard_d       = guard_q;
    fills_d       = fills_q;
    err_burst_d   = err_burst_q;
    err_tlast_d   = err_tlast_q;
`ifdef READOUT_WATCHDOG_EN
    wd_d          = wd_q;
    err_timeout_d = err_timeout_q;
`endif
    fill_header_fifo_rd_en = 1'b0;
    enable_reading         = 1'b0;
    hdr_valid              = 1'b0;
    seq_idle               = 1'b0;

    // A burst arriving in CHECK itself still counts toward the verdict taken that cycle.
    if ((state_q == ST_READ || state_q == ST_CHECK) && ddr3_rd_fifo_wr_en) begin
      if (burst_ctr_q != '1) burst_ctr_d = burst_ctr_q + 1'b1;
      last_tlast_d = ddr3_rd_fifo_input_tlast;
      if (ddr3_rd_fifo_input_tlast && burst_ctr_d != cnt_q) tlast_bad_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        seq_idle = 1'b1;
        if (!fill_header_fifo_empty && !readout_pause) state_d = ST_POP;
      end
      ST_POP: begin
        fill_header_fifo_rd_en = 1'b1;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        addr_d       = fill_header_fifo_out[ADDR_LSB +: ADDR_W];
        cnt_d        = fill_header_fifo_out[CNT_LSB +: CNT_W];
        info_d       = fill_header_fifo_out[INFO_LSB +: INFO_W];
        burst_ctr_d  = '0;
        last_tlast_d = 1'b0;
        tlast_bad_d  = 1'b0;
        state_d      = ST_HDR;
      end
      ST_HDR: begin
        hdr_valid = 1'b1;
        if (hdr_ack) state_d = (cnt_q == '0) ? ST_CHECK : ST_ARM;
      end
      ST_ARM: begin
        enable_reading = 1'b1;
        guard_d = '0;
`ifdef READOUT_WATCHDOG_EN
        wd_d = '0;
`endif
        state_d = ST_READ;
      end
      ST_READ: begin
        // reading_done may still be high from the previous fill for a couple of cycles.
        if (guard_q != 2'd2) guard_d = guard_q + 2'd1;
        else if (reading_done) state_d = ST_CHECK;
`ifdef READOUT_WATCHDOG_EN
        wd_d = wd_q + 24'd1;
        if (wd_q == TIMEOUT_CYCLES) begin
          state_d       = ST_CHECK;
          err_timeout_d = 1'b1;
        end
`endif
      end
      ST_CHECK: begin
        if (burst_ctr_d != cnt_q) err_burst_d = 1'b1;
        if (tlast_bad_d || (cnt_q != '0 && !last_tlast_d)) err_tlast_d = 1'b1;
        fills_d = fills_q + 24'd1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ddr3_rd_start_addr = addr_q;
  assign ddr3_rd_burst_cnt  = cnt_q;
  assign hdr_info           = info_q;
  assign fills_read         = fills_q;
  assign err_burst_mismatch = err_burst_q;
  assign err_tlast          = err_tlast_q;
`ifdef READOUT_WATCHDOG_EN
  assign err_timeout        = err_timeout_q;
`endif

endmodule

// File: tb/tb_ddr3_readout_sequencer.sv
// Scoreboard bench for ddr3_readout_sequencer: header FIFO and read-engine models feed
// the DUT, a monitor compares each header, arm and completed fill against a reference.
module tb_ddr3_readout_sequencer;
  import ddr3_readout_pkg::*;

  logic              clk125 = 1'b0;
  logic              reset_clk125 = 1'b1;
  logic              readout_pause = 1'b0;
  logic              fill_header_fifo_empty = 1'b1;
  logic              fill_header_fifo_rd_en;
  logic [HDR_W-1:0]  fill_header_fifo_out = '0;
  logic [22:0]       ddr3_rd_start_addr;
  logic [23:0]       ddr3_rd_burst_cnt;
  logic              enable_reading;
  logic              reading_done = 1'b0;
  logic              ddr3_rd_fifo_wr_en = 1'b0;
  logic              ddr3_rd_fifo_input_tlast = 1'b0;
  logic [INFO_W-1:0] hdr_info;
  logic              hdr_valid;
  logic              hdr_ack = 1'b0;
  logic [23:0]       fills_read;
  logic              err_burst_mismatch;
  logic              err_tlast;
  logic              seq_idle;

  typedef struct {
    logic [22:0]       addr;
    logic [23:0]       cnt;
    logic [INFO_W-1:0] info;
    int                nBursts;
    logic [15:0]       tlastMask;
    bit                stale;
    int                doneDelay;
  } fill_t;

  typedef struct {
    logic [22:0]       addr;
    logic [23:0]       cnt;
    logic [INFO_W-1:0] info;
    logic [23:0]       fills;
    bit                errBurst;
    bit                errTlast;
  } exp_t;

  logic [HDR_W-1:0] hdrQ[$];
  fill_t            planQ[$];
  exp_t             expQ[$];

  int          checks = 0;
  int          errors = 0;
  int          issued = 0;
  int          completed = 0;
  int          rdEnCount = 0;
  bit          monitorOn = 1'b0;
  logic [23:0] modelFills = '0;
  bit          modelErrBurst = 1'b0;
  bit          modelErrTlast = 1'b0;

  ddr3_readout_sequencer dut (
    .clk125                  (clk125),
    .reset_clk125            (reset_clk125),
    .readout_pause           (readout_pause),
    .fill_header_fifo_empty  (fill_header_fifo_empty),
    .fill_header_fifo_rd_en  (fill_header_fifo_rd_en),
    .fill_header_fifo_out    (fill_header_fifo_out),
    .ddr3_rd_start_addr      (ddr3_rd_start_addr),
    .ddr3_rd_burst_cnt       (ddr3_rd_burst_cnt),
    .enable_reading          (enable_reading),
    .reading_done            (reading_done),
    .ddr3_rd_fifo_wr_en      (ddr3_rd_fifo_wr_en),
    .ddr3_rd_fifo_input_tlast(ddr3_rd_fifo_input_tlast),
    .hdr_info                (hdr_info),
    .hdr_valid               (hdr_valid),
    .hdr_ack                 (hdr_ack),
    .fills_read              (fills_read),
    .err_burst_mismatch      (err_burst_mismatch),
    .err_tlast               (err_tlast),
    .seq_idle                (seq_idle)
  );

  always #4 clk125 = ~clk125;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference verdict for one fill: count must match, and tlast may appear only on burst
  // number cnt, which must also be the last burst delivered.
  function automatic void modelFill(input fill_t f, output bit eb, output bit et);
    eb = (f.nBursts != int'(f.cnt));
    et = 1'b0;
    for (int k = 1; k <= f.nBursts; k++)
      if (f.tlastMask[k-1] && k != int'(f.cnt)) et = 1'b1;
    if (f.cnt != 0 && (f.nBursts == 0 || !f.tlastMask[f.nBursts-1])) et = 1'b1;
  endfunction

  function automatic fill_t mkFill(input logic [22:0] addr, input int cnt, input int n,
                                   input logic [15:0] mask, input bit stale, input int dly);
    fill_t f;
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    f.addr = addr;
    f.cnt = 24'(cnt);
    f.info = r[INFO_W-1:0];
    f.nBursts = n;
    f.tlastMask = mask;
    f.stale = stale;
    f.doneDelay = dly;
    return f;
  endfunction

  function automatic fill_t randomFill();
    int cnt, n, mode;
    logic [15:0] mask;
    bit stale;
    cnt = $urandom_range(0, 6);
    n = ($urandom_range(0, 9) < 7) ? cnt : $urandom_range(0, 7);
    if (cnt == 0) n = 0;
    mask = '0;
    mode = $urandom_range(0, 5);
    if (mode <= 3 && cnt > 0 && cnt <= n) mask[cnt-1] = 1'b1;
    else if (mode == 4 && n > 0) mask[$urandom_range(0, n-1)] = 1'b1;
    stale = (n <= 2) && ($urandom_range(0, 1) == 1);
    return mkFill(23'($urandom), cnt, n, mask, stale, stale ? 0 : $urandom_range(0, 3));
  endfunction

  task automatic applyStimulus(input fill_t f);
    exp_t e;
    bit eb, et;
    modelFill(f, eb, et);
    modelFills = modelFills + 24'd1;
    modelErrBurst |= eb;
    modelErrTlast |= et;
    e.addr = f.addr;
    e.cnt = f.cnt;
    e.info = f.info;
    e.fills = modelFills;
    e.errBurst = modelErrBurst;
    e.errTlast = modelErrTlast;
    expQ.push_back(e);
    if (f.cnt != 0) planQ.push_back(f);
    hdrQ.push_back({f.info, f.cnt, f.addr});
    issued++;
  endtask

  task automatic waitDone(input int maxCycles);
    int n = 0;
    while (completed != issued && n < maxCycles) begin
      @(negedge clk125);
      n++;
    end
    checkOutput("fills_completed", 128'(completed), 128'(issued));
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_seq_idle"}, seq_idle, 1'b1);
    checkOutput({tag, "_rd_en"}, fill_header_fifo_rd_en, 1'b0);
    checkOutput({tag, "_enable_reading"}, enable_reading, 1'b0);
    checkOutput({tag, "_hdr_valid"}, hdr_valid, 1'b0);
    checkOutput({tag, "_addr"}, ddr3_rd_start_addr, 23'd0);
    checkOutput({tag, "_cnt"}, ddr3_rd_burst_cnt, 24'd0);
    checkOutput({tag, "_hdr_info"}, hdr_info, '0);
    checkOutput({tag, "_fills_read"}, fills_read, 24'd0);
    checkOutput({tag, "_err_burst"}, err_burst_mismatch, 1'b0);
    checkOutput({tag, "_err_tlast"}, err_tlast, 1'b0);
  endtask

  // Header FIFO (standard read) and packetizer acknowledge.
  initial begin : fifoDriver
    forever begin
      @(negedge clk125);
      if (fill_header_fifo_rd_en) begin
        if (hdrQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL fifo_underflow: got rd_en with empty FIFO, expected no pop");
        end else begin
          fill_header_fifo_out = hdrQ.pop_front();
        end
      end
      fill_header_fifo_empty = (hdrQ.size() == 0);
      hdr_ack = hdr_valid && ($urandom_range(0, 2) == 0);
    end
  end

  // Read engine: bursts begin the cycle after the arm pulse; stale fills keep reading_done high.
  initial begin : readEngine
    fill_t p;
    forever begin
      @(negedge clk125);
      ddr3_rd_fifo_wr_en = 1'b0;
      ddr3_rd_fifo_input_tlast = 1'b0;
      if (enable_reading && planQ.size() > 0) begin
        p = planQ.pop_front();
        if (!p.stale) reading_done = 1'b0;
        for (int b = 0; b < p.nBursts; b++) begin
          @(negedge clk125);
          ddr3_rd_fifo_wr_en = 1'b1;
          ddr3_rd_fifo_input_tlast = p.tlastMask[b];
          if (!p.stale && $urandom_range(0, 1) == 1) begin
            @(negedge clk125);
            ddr3_rd_fifo_wr_en = 1'b0;
            ddr3_rd_fifo_input_tlast = 1'b0;
          end
        end
        @(negedge clk125);
        ddr3_rd_fifo_wr_en = 1'b0;
        ddr3_rd_fifo_input_tlast = 1'b0;
        repeat (p.doneDelay) @(negedge clk125);
        reading_done = 1'b1;
      end
    end
  end

  // Monitor: pops the expected record when a header is presented, audits arm and completion.
  initial begin : monitor
    exp_t cur;
    bit haveCur = 1'b0;
    bit prevValid = 1'b0;
    logic [23:0] prevFills = '0;
    int armCount = 0;
    int armCycle = 0;
    int cycle = 0;
    forever begin
      @(negedge clk125);
      cycle++;
      if (!monitorOn) begin
        prevValid = hdr_valid;
        prevFills = fills_read;
        continue;
      end
      if (fill_header_fifo_rd_en) rdEnCount++;
      if (hdr_valid && !prevValid) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL hdr_unexpected: got hdr_valid, expected no header");
        end else begin
          cur = expQ.pop_front();
          haveCur = 1'b1;
          armCount = 0;
          checkOutput("hdr_info", hdr_info, cur.info);
        end
      end
      if (enable_reading && haveCur) begin
        armCount++;
        armCycle = cycle;
        checkOutput("arm_addr", ddr3_rd_start_addr, cur.addr);
        checkOutput("arm_cnt", ddr3_rd_burst_cnt, cur.cnt);
      end
      if (fills_read != prevFills && haveCur) begin
        checkOutput("fills_read", fills_read, cur.fills);
        checkOutput("err_burst_mismatch", err_burst_mismatch, cur.errBurst);
        checkOutput("err_tlast", err_tlast, cur.errTlast);
        checkOutput("arm_pulses", 128'(armCount), (cur.cnt != 0) ? 128'd1 : 128'd0);
        if (cur.cnt != 0) checkOutput("read_min_cycles", 128'((cycle - armCycle) >= 5), 128'd1);
        haveCur = 1'b0;
        completed++;
      end
      prevValid = hdr_valid;
      prevFills = fills_read;
    end
  end

  initial begin : timeLimit
    #400000;
    $display("[TB] FAIL global_timeout: got no finish, expected run to complete");
    $fatal(1, "[TB] time limit reached");
  end

  initial begin : stimulus
    int rdBefore;
    int n;
    repeat (3) @(negedge clk125);
    checkResetOutputs("reset");
    reset_clk125 = 1'b0;
    monitorOn = 1'b1;
    @(negedge clk125);

    applyStimulus(mkFill(23'h000100, 4, 4, 16'h0008, 1'b0, 3));
    applyStimulus(mkFill(23'h000200, 0, 0, 16'h0000, 1'b0, 0));
    applyStimulus(mkFill(23'h000300, 3, 3, 16'h0002, 1'b0, 1));
    applyStimulus(mkFill(23'h000400, 5, 4, 16'h0008, 1'b0, 2));
    applyStimulus(mkFill(23'h000500, 2, 2, 16'h0002, 1'b0, 1));
    applyStimulus(mkFill(23'h000600, 2, 2, 16'h0002, 1'b1, 0));
    waitDone(3000);

    readout_pause = 1'b1;
    rdBefore = rdEnCount;
    for (int i = 0; i < 3; i++) applyStimulus(randomFill());
    repeat (20) @(negedge clk125);
    checkOutput("pause_no_pop", 128'(rdEnCount - rdBefore), 128'd0);
    checkOutput("pause_idle", seq_idle, 1'b1);
    readout_pause = 1'b0;
    waitDone(3000);

    for (int i = 0; i < 25; i++) applyStimulus(randomFill());
    waitDone(10000);

    applyStimulus(mkFill(23'h7ABCDE, 4, 4, 16'h0008, 1'b0, 3));
    n = 0;
    while (!enable_reading && n < 500) begin
      @(negedge clk125);
      n++;
    end
    checkOutput("reach_arm", enable_reading, 1'b1);
    @(negedge clk125);
    checkOutput("busy_in_read", seq_idle, 1'b0);
    monitorOn = 1'b0;
    reset_clk125 = 1'b1;
    @(negedge clk125);
    checkResetOutputs("mid_reset");
    @(negedge clk125);
    reset_clk125 = 1'b0;
    repeat (6) @(negedge clk125);
    checkResetOutputs("after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
